// File: rtl/ahb_crc_accel.sv
// AHB-Lite slave wrapping a multi-cycle, MSB-first CRC engine on the EXTS bus.
// Optional build macro CRC_REFLECT_EN: reflect input bytes and the read-back CRC.
module ahb_crc_accel #(
  parameter logic [31:0] BASE_ADDR      = 32'hE800_0000,
  parameter int unsigned CRC_WIDTH      = 32,
  parameter logic [31:0] POLY           = 32'h04C1_1DB7,
  parameter logic [31:0] INIT_VAL       = 32'hFFFF_FFFF,
  parameter logic [31:0] XOR_OUT        = 32'h0000_0000,
  parameter int unsigned BITS_PER_CYCLE = 8
) (
  input  logic        EXTS_HCLK,
  input  logic        EXTS_HRST,
  input  logic        EXTS_HSEL,
  input  logic        EXTS_HREADY,
  input  logic [1:0]  EXTS_HTRANS,
  input  logic        EXTS_HWRITE,
  input  logic [2:0]  EXTS_HSIZE,
  input  logic [31:0] EXTS_HADDR,
  input  logic [31:0] EXTS_HWDATA,
  output logic [31:0] EXTS_HRDATA,
  output logic        EXTS_HREADYOUT,
  output logic        EXTS_HRESP
);

  localparam int unsigned BEATS = 32 / BITS_PER_CYCLE;
  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [CRC_WIDTH-1:0] POLY_W  = POLY[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] INIT_W  = INIT_VAL[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] XOUT_W  = XOR_OUT[CRC_WIDTH-1:0];
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_INIT   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t               state, state_nx;
  logic                 dp_write;
  logic [1:0]           dp_off;
  logic                 accept, addr_err, ready, resp, stall, complete;
  logic [31:0]          rd_word, rdata, word_in;
  logic [CRC_WIDTH-1:0] crc, init_reg, crc_rd;
  logic [31:0]          data_sr;
  logic                 busy, valid;
  logic [BCW-1:0]       beat;
  logic [7:0]           count;
  logic                 unused_bits;

  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] c_in,
                                                    input logic [BITS_PER_CYCLE-1:0] d);
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c = c_in;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      fb = c[CRC_WIDTH-1] ^ d[BITS_PER_CYCLE-1-i];
      c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY_W : '0);
    end
    return c;
  endfunction

`ifdef CRC_REFLECT_EN
  function automatic logic [31:0] refl_bytes(input logic [31:0] w);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) r[i] = w[i ^ 32'd7];
    return r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] refl_crc(input logic [CRC_WIDTH-1:0] c);
    logic [CRC_WIDTH-1:0] r;
    for (int unsigned i = 0; i < CRC_WIDTH; i++) r[i] = c[CRC_WIDTH-1-i];
    return r;
  endfunction

  assign word_in = refl_bytes(EXTS_HWDATA);
  assign crc_rd  = refl_crc(crc) ^ XOUT_W;
`else
  assign word_in = EXTS_HWDATA;
  assign crc_rd  = crc ^ XOUT_W;
`endif

  assign unused_bits = EXTS_HTRANS[0];

  assign accept   = EXTS_HSEL & EXTS_HREADY & EXTS_HTRANS[1];
  assign addr_err = (EXTS_HSIZE != 3'b010) || (EXTS_HADDR[1:0] != 2'b00) ||
                    (EXTS_HADDR[31:4] != BASE_ADDR[31:4]) ||
                    (EXTS_HWRITE && (EXTS_HADDR[3:2] == OFF_STATUS));

  always_comb begin
    rd_word = '0;
    case (dp_off)
      OFF_DATA:   rd_word[CRC_WIDTH-1:0] = crc_rd;
      OFF_STATUS: rd_word = {16'h0000, count, 6'b000000, valid, busy};
      OFF_CTRL:   rd_word = '0;
      default:    rd_word[CRC_WIDTH-1:0] = init_reg;
    endcase
  end

  // Stalled data phases keep the FSM in S_DATA; any completing phase may overlap the next address phase.
  always_comb begin
    state_nx = state;
    ready    = 1'b1;
    resp     = 1'b0;
    rdata    = '0;
    stall    = 1'b0;
    complete = 1'b0;
    case (state)
      S_DATA: begin
        stall    = busy && (dp_off != OFF_STATUS);
        ready    = !stall;
        complete = !stall;
        if (complete && !dp_write) rdata = rd_word;
      end
      S_ERR1: begin
        ready    = 1'b0;
        resp     = 1'b1;
        state_nx = S_ERR2;
      end
      S_ERR2: resp = 1'b1;
      default: ;
    endcase
    if (ready) state_nx = accept ? (addr_err ? S_ERR1 : S_DATA) : S_IDLE;
  end

  assign EXTS_HREADYOUT = ready;
  assign EXTS_HRESP     = resp;
  assign EXTS_HRDATA    = rdata;

  always_ff @(posedge EXTS_HCLK) begin
    if (EXTS_HRST) begin
      state    <= S_IDLE;
      dp_write <= 1'b0;
      dp_off   <= OFF_DATA;
    end else begin
      state <= state_nx;
      if (ready && accept) begin
        dp_write <= EXTS_HWRITE;
        dp_off   <= EXTS_HADDR[3:2];
      end
    end
  end

  // Writes only complete while idle, so they never collide with an engine step.
  always_ff @(posedge EXTS_HCLK) begin
    if (EXTS_HRST) begin
      crc      <= INIT_W;
      init_reg <= INIT_W;
      data_sr  <= '0;
      busy     <= 1'b0;
      beat     <= '0;
      valid    <= 1'b0;
      count    <= '0;
    end else begin
      if (busy) begin
        crc     <= crc_step(crc, data_sr[31 -: BITS_PER_CYCLE]);
        data_sr <= data_sr << BITS_PER_CYCLE;
        if (beat == LAST_BEAT) begin
          busy  <= 1'b0;
          beat  <= '0;
          count <= count + 8'd1;
          valid <= 1'b1;
        end else begin
          beat <= beat + BCW'(1);
        end
      end
      if (complete && dp_write) begin
        case (dp_off)
          OFF_DATA: begin
            data_sr <= word_in;
            busy    <= 1'b1;
            beat    <= '0;
          end
          OFF_CTRL: begin
            if (EXTS_HWDATA[0]) begin
              crc   <= init_reg;
              count <= '0;
              valid <= 1'b0;
            end
          end
          OFF_INIT: init_reg <= EXTS_HWDATA[CRC_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_crc_accel.sv
// Scoreboard bench for ahb_crc_accel: the driver queues expected responses,
// a negedge monitor pops and checks them as each data phase completes.
module tb_ahb_crc_accel;

  localparam logic [31:0] BASE = 32'hE800_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic        hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [31:0] hrdata;
  logic        hreadyout, hresp;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        resp;
    int          minw;
    int          maxw;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic dp = 1'b0;
  int   ws = 0;

  ahb_crc_accel #(.BASE_ADDR(BASE)) dut (
    .EXTS_HCLK      (clk),
    .EXTS_HRST      (rst),
    .EXTS_HSEL      (hsel),
    .EXTS_HREADY    (hreadyout),
    .EXTS_HTRANS    (htrans),
    .EXTS_HWRITE    (hwrite),
    .EXTS_HSIZE     (hsize),
    .EXTS_HADDR     (haddr),
    .EXTS_HWDATA    (hwdata),
    .EXTS_HRDATA    (hrdata),
    .EXTS_HREADYOUT (hreadyout),
    .EXTS_HRESP     (hresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      dp = 1'b0;
      ws = 0;
    end else begin
      if (dp) begin
        if (!hreadyout) begin
          ws++;
          check({cur.name, " wait hresp"}, {31'b0, hresp}, {31'b0, cur.resp});
          check({cur.name, " wait hrdata"}, hrdata, 32'h0);
        end else begin
          check({cur.name, " hresp"}, {31'b0, hresp}, {31'b0, cur.resp});
          check({cur.name, " hrdata"}, hrdata, cur.data);
          n_vec++;
          if (ws < cur.minw || ws > cur.maxw) begin
            n_err++;
            $display("FAIL %s waits: got %0d expected %0d..%0d", cur.name, ws, cur.minw, cur.maxw);
          end
          dp = 1'b0;
        end
      end
      if (hsel && htrans[1] && hreadyout) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected transfer: got accept expected none");
        end else begin
          cur = q.pop_front();
          dp  = 1'b1;
          ws  = 0;
        end
      end
    end
  end

  task automatic xfer(input string nm, input logic wr, input logic [3:0] off, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_resp,
                      input int minw, input int maxw);
    exp_t e;
    int   n;
    e.name = nm; e.data = exp_rd; e.resp = exp_resp; e.minw = minw; e.maxw = maxw;
    q.push_back(e);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    haddr  = BASE | {28'h0, off};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hreadyout && n < 64);
    if (!hreadyout) begin
      n_vec++;
      n_err++;
      $display("FAIL %s accept timeout: got hreadyout=0 expected 1", nm);
    end
    @(posedge clk);
    #1;
    hwdata = wd;
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic wr(input string nm, input logic [3:0] off, input logic [31:0] d,
                    input int minw, input int maxw);
    xfer(nm, 1'b1, off, 3'b010, d, 32'h0, 1'b0, minw, maxw);
  endtask

  task automatic rd(input string nm, input logic [3:0] off, input logic [31:0] exp,
                    input int minw, input int maxw);
    xfer(nm, 1'b0, off, 3'b010, 32'h0, exp, 1'b0, minw, maxw);
  endtask

  task automatic err(input string nm, input logic w, input logic [3:0] off, input logic [2:0] sz);
    xfer(nm, w, off, sz, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset hreadyout", {31'b0, hreadyout}, 32'h1);
    check("reset hresp", {31'b0, hresp}, 32'h0);
    check("reset hrdata", hrdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    rd("t1 status", 4'h4, 32'h0000_0000, 0, 0);
    rd("t1 data",   4'h0, 32'hFFFF_FFFF, 0, 0);
    rd("t1 init",   4'hC, 32'hFFFF_FFFF, 0, 0);

    wr("t2 init",   4'hC, 32'h0000_0000, 0, 0);
    wr("t2 ctrl",   4'h8, 32'h0000_0001, 0, 0);
    wr("t2 data",   4'h0, 32'h0000_0001, 0, 0);
    rd("t2 crc",    4'h0, 32'h04C1_1DB7, 3, 4);
    rd("t2 status", 4'h4, 32'h0000_0102, 0, 0);

    wr("t3a init",  4'hC, 32'h0000_0000, 0, 0);
    wr("t3a ctrl",  4'h8, 32'h0000_0001, 0, 0);
    wr("t3a data",  4'h0, 32'h0000_0002, 0, 0);
    rd("t3a crc",   4'h0, 32'h0982_3B6E, 3, 4);
    wr("t3b init",  4'hC, 32'hFFFF_FFFF, 0, 0);
    wr("t3b ctrl",  4'h8, 32'h0000_0001, 0, 0);
    wr("t3b data",  4'h0, 32'hFFFF_FFFE, 0, 0);
    rd("t3b crc",   4'h0, 32'h04C1_1DB7, 3, 4);
    rd("ctrl read", 4'h8, 32'h0000_0000, 0, 0);

    err("t4 wr status",     1'b1, 4'h4, 3'b010);
    err("t4 byte rd",       1'b0, 4'h0, 3'b000);
    err("t4 unaligned init", 1'b1, 4'hE, 3'b010);
    err("t4 half init",     1'b1, 4'hC, 3'b001);
    rd("t4 data",   4'h0, 32'h04C1_1DB7, 0, 0);
    rd("t4 status", 4'h4, 32'h0000_0102, 0, 0);
    rd("t4 init",   4'hC, 32'hFFFF_FFFF, 0, 0);

    wr("t6 init",   4'hC, 32'h0000_0000, 0, 0);
    wr("t6 ctrl",   4'h8, 32'h0000_0001, 0, 0);
    wr("t6 data1",  4'h0, 32'h0000_0000, 0, 0);
    wr("t6 data2",  4'h0, 32'h0000_0000, 3, 4);
    rd("t6 crc",    4'h0, 32'h0000_0000, 3, 4);
    rd("t6 status", 4'h4, 32'h0000_0202, 0, 0);

    // IDLE transfer and a deselected NONSEQ must both be ignored
    hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = BASE; hsize = 3'b010;
    @(posedge clk); #1 hwdata = 32'hFFFF_FFFF;
    hsel = 1'b0; htrans = 2'b10; haddr = BASE | 32'h8;
    @(posedge clk); #1 hwdata = 32'h0000_0001;
    @(posedge clk); #1;
    htrans = 2'b00; hwrite = 1'b0;
    rd("idle status", 4'h4, 32'h0000_0202, 0, 0);
    rd("idle crc",    4'h0, 32'h0000_0000, 0, 0);

    wr("t5 data", 4'h0, 32'h1234_5678, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rd("t5 status", 4'h4, 32'h0000_0000, 0, 0);
    rd("t5 crc",    4'h0, 32'hFFFF_FFFF, 0, 0);
    rd("t5 init",   4'hC, 32'hFFFF_FFFF, 0, 0);

    n = 0;
    while ((q.size() != 0 || dp) && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain queue", 32'(q.size()), 32'h0);
    check("drain dphase", {31'b0, dp}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
